// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative multiply/divide unit for the execute stage.
//
// One result bit is produced per clock. Multiplies use unsigned shift-add and
// divides use unsigned restoring division. A start/busy/done handshake
// connects the unit to the control unit, which stalls while busy is high. The
// result goes back to the register file as a one-cycle writeback pulse.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   start        request; only sampled in IDLE
//   flush        synchronous abort; the next edge always lands in IDLE
//   op           00 MUL low, 01 UMUL high, 10 UDIV, 11 UREM
//   operand_a    multiplicand / dividend
//   operand_b    multiplier / divisor
//   rd_in        destination register index
//   busy         high while iterating (CALC)
//   done         one-cycle pulse in DONE
//   div_by_zero  qualified by done; divide op with operand_b == 0
//   wb_en        register-file write enable (same as done)
//   wb_addr      destination index latched with the result
//   wb_data      result; holds until the next completed operation
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [3:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             wb_en,
  output logic [3:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;        // multiplicand, or dividend shifted out MSB first
  logic [WIDTH-1:0]   b_q;        // multiplier shifted out LSB first, or divisor
  logic [3:0]         rd_q;
  logic               dbz_q;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [CW-1:0]      cnt;

  logic               accept, last_iter;
  logic [WIDTH-1:0]   addend, rem_diff, rem_new;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic               rem_ge;

  assign accept    = (state == IDLE) && start && !flush;
  assign last_iter = (state == CALC) && (cnt == LAST);

  // State register
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples values from before the edge regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  // NOTE: every output of a combinational block gets a default first; otherwise
  // a path that skips an assignment infers a latch.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start)     state_nxt = CALC;
        CALC:    if (last_iter) state_nxt = DONE;
        DONE:                   state_nxt = IDLE;
        default:                state_nxt = IDLE;
      endcase
    end
  end

  // One iteration of either algorithm. acc holds {high, low}:
  //   multiply: running partial product, shifted right once per step
  //   divide:   {remainder, quotient}; quotient bits enter at the LSB
  always_comb begin
    addend   = b_q[0] ? a_q : '0;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    rem_sh   = {acc[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, b_q});
    // Only used when rem_ge, so the result always fits in WIDTH bits.
    rem_diff = rem_sh[WIDTH-1:0] - b_q;
    rem_new  = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
    if (op_q[1]) acc_nxt = {rem_new, acc[WIDTH-2:0], rem_ge};
    else         acc_nxt = {mul_sum, acc[WIDTH-1:1]};
  end

  // Datapath. A divisor of zero needs no special path: every step subtracts
  // zero. This gives an all-ones quotient and a remainder equal to the dividend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      dbz_q   <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (accept) begin
      op_q  <= op;
      a_q   <= operand_a;
      b_q   <= operand_b;
      rd_q  <= rd_in;
      dbz_q <= op[1] && (operand_b == '0);
      acc   <= '0;
      cnt   <= '0;
    end else if ((state == CALC) && !flush) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (op_q[1]) a_q <= a_q << 1;
      else         b_q <= b_q >> 1;
      if (last_iter) begin
        // op[0] selects the upper half: product high or remainder.
        wb_data <= op_q[0] ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
        wb_addr <= rd_q;
      end
    end
  end

  assign busy        = (state == CALC);
  assign done        = (state == DONE);
  assign wb_en       = done;
  assign div_by_zero = done && dbz_q;

endmodule
